// File: rtl/pattern_edit_engine.sv
// Read-modify-write editor for the pattern-cell RAM. Keyboard edit commands are
// edge-detected and auto-repeated, then applied to the cell under the cursor.
module pattern_edit_engine #(
  parameter int                COLS         = 80,
  parameter int                ROWS         = 30,
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] MAX_VAL      = 8'd95,
  parameter logic [DATA_W-1:0] EMPTY_VAL    = 8'hFF,
  parameter int                REPEAT_DELAY = 25000000,
  parameter int                REPEAT_RATE  = 5000000
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [1:0]        user_edit,
  input  logic [6:0]        cursor_x,
  input  logic [6:0]        cursor_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              edit_done
);

  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {IDLE, RD, MOD, WR} state_t;

  state_t            state_q;
  logic [1:0]        edit_prev_q, op_q;
  logic [CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_calc;
  logic [DATA_W-1:0] wdata_q, new_val;
  logic              rd_en_q, wr_en_q, busy_q, done_q;
  logic              held, trigger, rpt_fire, go, in_range;

  assign trigger  = (user_edit != 2'b00) && (user_edit != edit_prev_q);
  assign held     = (user_edit == edit_prev_q) && (user_edit == 2'b01 || user_edit == 2'b10);
  assign rpt_fire = held && (rep_cnt_q == CNT_W'(REPEAT_DELAY - 1));
  assign go       = trigger || rpt_fire;
  assign in_range = (cursor_x < 7'(COLS)) && (cursor_y < 7'(ROWS));
  assign addr_calc = ADDR_W'(cursor_y) * ADDR_W'(COLS) + ADDR_W'(cursor_x);

  // After the first repeat the counter is rewound so later repeats come every REPEAT_RATE.
  always_comb begin
    rep_cnt_d = '0;
    if (held) begin
      if (rpt_fire) rep_cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
      else          rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      edit_prev_q <= 2'b00;
      rep_cnt_q   <= '0;
    end else begin
      edit_prev_q <= user_edit;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  always_comb begin
    new_val = mem_rdata;
    if (op_q == 2'b01) begin
      if (mem_rdata == EMPTY_VAL)   new_val = '0;
      else if (mem_rdata < MAX_VAL) new_val = mem_rdata + 1'b1;
      else                          new_val = MAX_VAL;
    end else if (mem_rdata != EMPTY_VAL && mem_rdata != '0) begin
      new_val = mem_rdata - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (go && in_range) begin
          op_q   <= user_edit;
          addr_q <= addr_calc;
          busy_q <= 1'b1;
          if (user_edit == 2'b11) begin
            state_q <= WR;
            wdata_q <= EMPTY_VAL;
            wr_en_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD;
            rd_en_q <= 1'b1;
          end
        end
        RD: state_q <= MOD;
        MOD: begin
          state_q <= WR;
          wdata_q <= new_val;
          wr_en_q <= 1'b1;
          done_q  <= 1'b1;
        end
        WR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign edit_done = done_q;

endmodule
